// File: rtl/key_led_pkg.sv
// Shared constants for the front-panel key/LED controller.
package key_led_pkg;

    // LED pattern modes
    localparam logic [1:0] MODE_OFF   = 2'd0;
    localparam logic [1:0] MODE_ON    = 2'd1;
    localparam logic [1:0] MODE_BLINK = 2'd2;
    localparam logic [1:0] MODE_CHASE = 2'd3;

    // Per-key debounce states; the unused code 2'd3 falls back to DB_REL
    typedef enum logic [1:0] {
        DB_REL  = 2'd0,
        DB_P1   = 2'd1,
        DB_HELD = 2'd2
    } db_state_e;

    // Key roles, lower index wins arbitration
    localparam int unsigned KEY_NEXT = 0;
    localparam int unsigned KEY_PREV = 1;
    localparam int unsigned KEY_EN   = 2;
    localparam int unsigned KEY_CLR  = 3;
    localparam int unsigned NUM_KEYS = 4;

endpackage

// File: rtl/key_debounce.sv
// One push-button: 2-flop synchronizer, tick-paced debounce FSM, press pulse.
module key_debounce
    import key_led_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic key_n,
    output logic evt
);

    logic      sync1_q;
    logic      sync2_q;
    db_state_e state_q;
    db_state_e state_d;
    logic      evt_q;
    logic      evt_d;

    // Synchronizer; idles high (released)
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= key_n;
            sync2_q <= sync1_q;
        end
    end

    // Debounce state and registered press pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= DB_REL;
            evt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            evt_q   <= evt_d;
        end
    end

    // Advance only on tick; pulse on the P1 -> HELD transition
    always_comb begin
        state_d = state_q;
        evt_d   = 1'b0;
        if (tick) begin
            case (state_q)
                DB_REL: begin
                    if (!sync2_q) state_d = DB_P1;
                end
                DB_P1: begin
                    if (!sync2_q) begin
                        state_d = DB_HELD;
                        evt_d   = 1'b1;
                    end else begin
                        state_d = DB_REL;
                    end
                end
                DB_HELD: begin
                    if (sync2_q) state_d = DB_REL;
                end
                default: state_d = DB_REL;
            endcase
        end
    end

    assign evt = evt_q;

endmodule

// File: rtl/key_led_ctrl.sv
// Front-panel controller: shared tick, 4 debounced keys, press arbiter,
// and the OFF/ON/BLINK/CHASE LED sequencer with global enable.
module key_led_ctrl
    import key_led_pkg::*;
#(
    parameter int unsigned TICK_DIV    = 500000,
    parameter int unsigned NUM_LEDS    = 4,
    parameter int unsigned BLINK_TICKS = 50,
    parameter int unsigned CHASE_TICKS = 25
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [3:0]          key_n,
    output logic [NUM_LEDS-1:0] led,
    output logic [1:0]          mode,
    output logic                led_en,
    output logic [3:0]          key_evt
);

    localparam int unsigned CW       = $clog2(TICK_DIV);
    localparam int unsigned ANIM_MAX = (BLINK_TICKS > CHASE_TICKS) ? BLINK_TICKS : CHASE_TICKS;
    localparam int unsigned AW       = (ANIM_MAX > 1) ? $clog2(ANIM_MAX) : 1;

    logic [CW-1:0]       cnt_q;
    logic [CW-1:0]       cnt_d;
    logic                tick_c;
    logic [3:0]          evt_c;
    logic [3:0]          pend_q;
    logic [3:0]          pend_d;
    logic [3:0]          grant_c;
    logic [1:0]          mode_q;
    logic [1:0]          mode_d;
    logic                en_q;
    logic                en_d;
    logic [AW-1:0]       anim_q;
    logic [AW-1:0]       anim_d;
    logic                phase_q;
    logic                phase_d;
    logic [NUM_LEDS-1:0] pos_q;
    logic [NUM_LEDS-1:0] pos_d;
    logic [NUM_LEDS-1:0] led_q;
    logic [NUM_LEDS-1:0] led_d;
    logic                mode_chg_c;

    // Free-running tick divider
    always_comb begin
        tick_c = (cnt_q == CW'(TICK_DIV - 1));
        cnt_d  = tick_c ? '0 : cnt_q + CW'(1);
    end

    // One debouncer per key
    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        key_debounce u_db (
            .clk   (clk),
            .reset (reset),
            .tick  (tick_c),
            .key_n (key_n[g]),
            .evt   (evt_c[g])
        );
    end

    // Pending presses; lowest index is served first, one per clk
    always_comb begin
        grant_c = pend_q & (~pend_q + 4'd1);
        pend_d  = (pend_q & ~grant_c) | evt_c;
    end

    // Command execution and animation stepping; a mode change restarts the pattern
    always_comb begin
        mode_d     = mode_q;
        en_d       = en_q;
        anim_d     = anim_q;
        phase_d    = phase_q;
        pos_d      = pos_q;
        mode_chg_c = 1'b0;

        if (tick_c) begin
            if (mode_q == MODE_BLINK) begin
                if (anim_q == AW'(BLINK_TICKS - 1)) begin
                    anim_d  = '0;
                    phase_d = ~phase_q;
                end else begin
                    anim_d = anim_q + AW'(1);
                end
            end else if (mode_q == MODE_CHASE) begin
                if (anim_q == AW'(CHASE_TICKS - 1)) begin
                    anim_d = '0;
                    pos_d  = {pos_q[NUM_LEDS-2:0], pos_q[NUM_LEDS-1]};
                end else begin
                    anim_d = anim_q + AW'(1);
                end
            end
        end

        if (grant_c[KEY_NEXT]) begin
            mode_d     = mode_q + 2'd1;
            mode_chg_c = 1'b1;
        end
        if (grant_c[KEY_PREV]) begin
            mode_d     = mode_q - 2'd1;
            mode_chg_c = 1'b1;
        end
        if (grant_c[KEY_EN]) begin
            en_d = ~en_q;
        end
        if (grant_c[KEY_CLR]) begin
            mode_d     = MODE_OFF;
            en_d       = 1'b1;
            mode_chg_c = 1'b1;
        end

        if (mode_chg_c) begin
            anim_d  = '0;
            phase_d = 1'b1;
            pos_d   = NUM_LEDS'(1);
        end
    end

    // LED pattern from the current mode/animation state
    always_comb begin
        led_d = '0;
        if (en_q) begin
            case (mode_q)
                MODE_ON:    led_d = '1;
                MODE_BLINK: led_d = {NUM_LEDS{phase_q}};
                MODE_CHASE: led_d = pos_q;
                default:    led_d = '0;
            endcase
        end
    end

    // All controller state
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            pend_q  <= '0;
            mode_q  <= MODE_OFF;
            en_q    <= 1'b1;
            anim_q  <= '0;
            phase_q <= 1'b1;
            pos_q   <= NUM_LEDS'(1);
            led_q   <= '0;
        end else begin
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            mode_q  <= mode_d;
            en_q    <= en_d;
            anim_q  <= anim_d;
            phase_q <= phase_d;
            pos_q   <= pos_d;
            led_q   <= led_d;
        end
    end

    assign led     = led_q;
    assign mode    = mode_q;
    assign led_en  = en_q;
    assign key_evt = evt_c;

endmodule

// File: tb/tb_key_led_ctrl.sv
// Directed bench for key_led_ctrl with a short tick (4 clks) and 2-tick animation steps.
module tb_key_led_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] key_n;
    logic [3:0] led;
    logic [1:0] mode;
    logic       led_en;
    logic [3:0] key_evt;

    int total = 0;
    int bad   = 0;
    int ev_cnt [4] = '{0, 0, 0, 0};

    key_led_ctrl #(
        .TICK_DIV    (4),
        .NUM_LEDS    (4),
        .BLINK_TICKS (2),
        .CHASE_TICKS (2)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .key_n   (key_n),
        .led     (led),
        .mode    (mode),
        .led_en  (led_en),
        .key_evt (key_evt)
    );

    always #5 clk = ~clk;

    // Count high samples of each event line (a clean pulse counts once)
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) if (key_evt[i]) ev_cnt[i] = ev_cnt[i] + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Hold one key low for a fixed number of clks, then let things settle
    task automatic press_key(input int idx, input int nclk);
        key_n[idx] = 1'b0;
        repeat (nclk) @(negedge clk);
        key_n = 4'hF;
        repeat (8) @(negedge clk);
    endtask

    // Hold a key until mode reaches the expected value (bounded), then release
    task automatic press_until_mode(input string tag, input int idx, input logic [1:0] exp_mode);
        int n;
        n = 0;
        key_n[idx] = 1'b0;
        while (mode !== exp_mode && n < 40) begin
            @(negedge clk);
            n++;
        end
        key_n = 4'hF;
        chk(tag, 32'(mode), 32'(exp_mode));
    endtask

    // Wait for led to change (bounded); returns clks waited
    task automatic wait_led_change(output int n);
        logic [3:0] prev;
        prev = led;
        n = 0;
        while (led === prev && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int         n;
        int         snap;
        logic [3:0] acc;
        logic [3:0] exp_led;

        reset = 1'b1;
        key_n = 4'hF;
        repeat (3) @(negedge clk);
        chk("rst_led", 32'(led), 32'h0);
        chk("rst_mode", 32'(mode), 32'h0);
        chk("rst_en", 32'(led_en), 32'h1);
        chk("rst_evt", 32'(key_evt), 32'h0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // First press: event, then mode two clks later, led one clk after that
        snap = ev_cnt[0];
        key_n[0] = 1'b0;
        n = 0;
        while (!key_evt[0] && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("lat_evt_seen", 32'(key_evt[0]), 32'h1);
        chk("lat_mode_e0", 32'(mode), 32'h0);
        @(negedge clk);
        chk("lat_mode_e1", 32'(mode), 32'h0);
        @(negedge clk);
        chk("lat_mode_e2", 32'(mode), 32'h1);
        @(negedge clk);
        chk("lat_led_on", 32'(led), 32'hF);
        repeat (4) @(negedge clk);
        key_n = 4'hF;
        repeat (12) @(negedge clk);
        chk("press1_evts", 32'(ev_cnt[0] - snap), 32'h1);

        // Long hold: exactly one event
        snap = ev_cnt[0];
        press_key(0, 80);
        chk("hold_evts", 32'(ev_cnt[0] - snap), 32'h1);
        chk("hold_mode", 32'(mode), 32'h2);
        press_until_mode("prev_to_on", 1, 2'd1);
        repeat (10) @(negedge clk);

        // Single-tick glitch
        snap = ev_cnt[0];
        key_n[0] = 1'b0;
        repeat (4) @(negedge clk);
        key_n = 4'hF;
        repeat (16) @(negedge clk);
        chk("glitch_evts", 32'(ev_cnt[0] - snap), 32'h0);
        chk("glitch_mode", 32'(mode), 32'h1);

        // Simultaneous key0 + key2 from ON
        key_n = 4'b1010;
        n = 0;
        while (key_evt == 4'h0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("simul_evt", 32'(key_evt), 32'h5);
        @(negedge clk);
        chk("simul_mode_e1", 32'(mode), 32'h1);
        @(negedge clk);
        chk("simul_mode_e2", 32'(mode), 32'h2);
        chk("simul_en_e2", 32'(led_en), 32'h1);
        @(negedge clk);
        chk("simul_mode_e3", 32'(mode), 32'h2);
        chk("simul_en_e3", 32'(led_en), 32'h0);
        key_n = 4'hF;
        repeat (2) @(negedge clk);
        acc = 4'h0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            acc = acc | led;
        end
        chk("blink_disabled_led", 32'(acc), 32'h0);

        // Re-enable, then step into CHASE
        press_key(2, 12);
        chk("reenable", 32'(led_en), 32'h1);
        press_until_mode("to_chase", 0, 2'd3);
        @(negedge clk);
        chk("chase_start", 32'(led), 32'h1);
        exp_led = 4'b0001;
        for (int s = 0; s < 4; s++) begin
            wait_led_change(n);
            exp_led = {exp_led[2:0], exp_led[3]};
            chk("chase_step", 32'(led), 32'(exp_led));
            if (s > 0) chk("chase_period", 32'(n), 32'd8);
        end

        // PREV from CHASE -> BLINK restarts in the on phase
        press_until_mode("chase_to_blink", 1, 2'd2);
        @(negedge clk);
        chk("blink_start", 32'(led), 32'hF);
        wait_led_change(n);
        chk("blink_off", 32'(led), 32'h0);
        wait_led_change(n);
        chk("blink_on", 32'(led), 32'hF);
        chk("blink_period", 32'(n), 32'd8);

        // CLR to OFF, PREV wraps to CHASE, disable, CLR restores enable
        press_until_mode("clr_off", 3, 2'd0);
        @(negedge clk);
        chk("clr_led", 32'(led), 32'h0);
        repeat (10) @(negedge clk);
        press_until_mode("prev_wrap", 1, 2'd3);
        repeat (10) @(negedge clk);
        press_key(2, 12);
        chk("disable", 32'(led_en), 32'h0);
        press_until_mode("clr2_off", 3, 2'd0);
        @(negedge clk);
        chk("clr2_en", 32'(led_en), 32'h1);
        chk("clr2_led", 32'(led), 32'h0);
        repeat (10) @(negedge clk);

        // Reset while the key has just reached HELD: pending press is dropped
        key_n[0] = 1'b0;
        n = 0;
        while (!key_evt[0] && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("rstmid_evt_seen", 32'(key_evt[0]), 32'h1);
        reset = 1'b1;
        @(negedge clk);
        chk("rstmid_mode", 32'(mode), 32'h0);
        chk("rstmid_evt", 32'(key_evt), 32'h0);
        key_n = 4'hF;
        @(negedge clk);
        reset = 1'b0;
        snap = ev_cnt[0];
        repeat (24) @(negedge clk);
        chk("rstmid_no_evt", 32'(ev_cnt[0] - snap), 32'h0);
        chk("rstmid_mode_after", 32'(mode), 32'h0);
        chk("rstmid_en_after", 32'(led_en), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
